// File: rtl/hdmi_config_sequencer_if.sv
// I2C writer handshake between the HDMI config sequencer (master) and the downstream I2C writer (slave).
interface hdmi_config_sequencer_if;
    logic [23:0] i2cData;
    logic        i2cGo;
    logic        i2cComplete;

    modport master (output i2cData, output i2cGo, input i2cComplete);
    modport slave  (input i2cData, input i2cGo, output i2cComplete);
endinterface

// File: rtl/hdmi_config_sequencer.sv
// Walks a fixed 12-entry HDMI transmitter register table through an I2C writer, with timeouts and retries.
// Optional HDMI_HPD_REINIT_EN: adds an hpd input whose rising edge in DONE restarts the whole sequence.
module hdmi_config_sequencer #(
    parameter int unsigned powerUpCycles = 10_000_000,
    parameter int unsigned gapCycles     = 1000,
    parameter int unsigned startTimeout  = 1024,
    parameter int unsigned busyTimeout   = 65536,
    parameter int unsigned maxRetries    = 3
) (
    input  logic                           refClock,
    input  logic                           reset,
`ifdef HDMI_HPD_REINIT_EN
    input  logic                           hpd,
`endif
    hdmi_config_sequencer_if.master        i2c,
    output logic                           configBusy,
    output logic                           configDone,
    output logic                           configError,
    output logic [3:0]                     entryIndex
);

    localparam int unsigned NUM_ENTRIES = 12;
    localparam int unsigned MAX_PG      = (powerUpCycles > gapCycles) ? powerUpCycles : gapCycles;
    localparam int unsigned MAX_SB      = (startTimeout > busyTimeout) ? startTimeout : busyTimeout;
    localparam int unsigned CNT_MAX     = (MAX_PG > MAX_SB) ? MAX_PG : MAX_SB;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1) + 1;
    localparam int unsigned RETRY_W     = $clog2(maxRetries + 1) + 1;

    typedef enum logic [2:0] {
        WAIT_PWR,
        LOAD,
        GO,
        BUSY,
        GAP,
        DONE
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [RETRY_W-1:0]   retry_q;
    logic                 retry_pend_q;
    logic [3:0]           idx_q;
    logic [23:0]          data_q;
    logic                 go_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 retry_left_c;
    logic                 hpd_rise_c;

    function automatic logic [23:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_word = 24'h724110;
            4'd1:    cfg_word = 24'h729803;
            4'd2:    cfg_word = 24'h729AE0;
            4'd3:    cfg_word = 24'h729C30;
            4'd4:    cfg_word = 24'h729D61;
            4'd5:    cfg_word = 24'h72A2A4;
            4'd6:    cfg_word = 24'h72A3A4;
            4'd7:    cfg_word = 24'h72E0D0;
            4'd8:    cfg_word = 24'h72F900;
            4'd9:    cfg_word = 24'h721500;
            4'd10:   cfg_word = 24'h721702;
            4'd11:   cfg_word = 24'h72AF06;
            default: cfg_word = 24'h000000;
        endcase
    endfunction

    assign retry_left_c = (retry_q < RETRY_W'(maxRetries));

`ifdef HDMI_HPD_REINIT_EN
    logic hpd_meta_q;
    logic hpd_sync_q;
    logic hpd_prev_q;

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge refClock) begin
        if (reset) begin
            hpd_meta_q <= 1'b0;
            hpd_sync_q <= 1'b0;
            hpd_prev_q <= 1'b0;
        end else begin
            hpd_meta_q <= hpd;
            hpd_sync_q <= hpd_meta_q;
            hpd_prev_q <= hpd_sync_q;
        end
    end

    assign hpd_rise_c = hpd_sync_q & ~hpd_prev_q;
`else
    assign hpd_rise_c = 1'b0;
`endif

    // Sequencer FSM; every output is a register updated on the transition that sets it.
    always_ff @(posedge refClock) begin
        if (reset) begin
            state_q      <= WAIT_PWR;
            cnt_q        <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            idx_q        <= '0;
            data_q       <= '0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                WAIT_PWR: begin
                    if (cnt_q < CNT_W'(powerUpCycles)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (i2c.i2cComplete) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    data_q       <= cfg_word(idx_q);
                    if (!retry_pend_q) begin
                        retry_q <= '0;
                    end
                    retry_pend_q <= 1'b0;
                    cnt_q        <= '0;
                    go_q         <= 1'b1;
                    state_q      <= GO;
                end

                // Completion edge is tested before the timeout so a coincident edge wins.
                GO: begin
                    if (!i2c.i2cComplete) begin
                        go_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end else if (cnt_q >= CNT_W'(startTimeout)) begin
                        go_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= GAP;
                        if (retry_left_c) begin
                            retry_q      <= retry_q + RETRY_W'(1);
                            retry_pend_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                BUSY: begin
                    if (i2c.i2cComplete) begin
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else if (cnt_q >= CNT_W'(busyTimeout)) begin
                        cnt_q   <= '0;
                        state_q <= GAP;
                        if (retry_left_c) begin
                            retry_q      <= retry_q + RETRY_W'(1);
                            retry_pend_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // A pending retry reloads the same entry; otherwise advance or finish.
                GAP: begin
                    if (cnt_q < CNT_W'(gapCycles)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                        if (retry_pend_q) begin
                            state_q <= LOAD;
                        end else if (idx_q == 4'(NUM_ENTRIES - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= LOAD;
                        end
                    end
                end

                DONE: begin
                    if (hpd_rise_c) begin
                        idx_q   <= '0;
                        retry_q <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= WAIT_PWR;
                    end
                end

                default: begin
                    go_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT_PWR;
                end
            endcase
        end
    end

    assign i2c.i2cData  = data_q;
    assign i2c.i2cGo    = go_q;
    assign configBusy   = busy_q;
    assign configDone   = done_q;
    assign configError  = err_q;
    assign entryIndex   = idx_q;

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Scoreboard bench for hdmi_config_sequencer: a randomized I2C writer model plus an expected-start queue.
module tb_hdmi_config_sequencer;

    localparam int unsigned PWR_CYC   = 20;
    localparam int unsigned GAP_CYC   = 4;
    localparam int unsigned START_TO  = 16;
    localparam int unsigned BUSY_TO   = 64;
    localparam int unsigned RETRIES   = 3;
    localparam int          LIMIT     = 20000;

    localparam logic [23:0] CFG_TABLE [12] = '{
        24'h724110, 24'h729803, 24'h729AE0, 24'h729C30, 24'h729D61, 24'h72A2A4,
        24'h72A3A4, 24'h72E0D0, 24'h72F900, 24'h721500, 24'h721702, 24'h72AF06
    };

    logic        refClock;
    logic        reset;
    logic        configBusy;
    logic        configDone;
    logic        configError;
    logic [3:0]  entryIndex;
`ifdef HDMI_HPD_REINIT_EN
    logic        hpd;
`endif

    hdmi_config_sequencer_if i2c ();

    hdmi_config_sequencer #(
        .powerUpCycles (PWR_CYC),
        .gapCycles     (GAP_CYC),
        .startTimeout  (START_TO),
        .busyTimeout   (BUSY_TO),
        .maxRetries    (RETRIES)
    ) dut (
        .refClock    (refClock),
        .reset       (reset),
`ifdef HDMI_HPD_REINIT_EN
        .hpd         (hpd),
`endif
        .i2c         (i2c.master),
        .configBusy  (configBusy),
        .configDone  (configDone),
        .configError (configError),
        .entryIndex  (entryIndex)
    );

    initial refClock = 1'b0;
    always #5 refClock = ~refClock;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [23:0] sb_q [$];
    logic        exp_err;

    // Writer model knobs.
    bit          ign_en     = 1'b0;
    logic [23:0] ign_word   = 24'h0;
    int          fixed_drop = 0;
    int          busy_lo    = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: each entry is tried once, an unanswered entry 1+RETRIES times.
    task automatic expect_sequence(input bit ign, input int ign_idx);
        for (int e = 0; e < 12; e++) begin
            int attempts;
            attempts = (ign && e == ign_idx) ? 1 + int'(RETRIES) : 1;
            for (int a = 0; a < attempts; a++) sb_q.push_back(CFG_TABLE[e]);
        end
        exp_err = ign;
    endtask

    // I2C writer: drops complete some cycles after a start, raises it again after a busy period.
    initial begin
        int d;
        int b;
        i2c.i2cComplete = 1'b1;
        forever begin
            @(posedge refClock); #1;
            if (!reset && i2c.i2cGo && i2c.i2cComplete && !(ign_en && i2c.i2cData == ign_word)) begin
                d = (fixed_drop != 0) ? fixed_drop : int'($urandom_range(1, 6));
                repeat (d) @(posedge refClock);
                #1 i2c.i2cComplete = 1'b0;
                b = int'($urandom_range(busy_lo, 20));
                repeat (b) @(posedge refClock);
                #1 i2c.i2cComplete = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every new start and checks go-drop timing.
    bit prev_go   = 1'b0;
    bit prev_drop = 1'b0;
    always @(negedge refClock) begin
        logic [23:0] exp_w;
        if (reset) begin
            prev_go   = 1'b0;
            prev_drop = 1'b0;
        end else begin
            if (prev_drop) check("go_drop", 32'(i2c.i2cGo), 32'd0);
            if (i2c.i2cGo && !prev_go) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL extra_start: got %06h, expected no start", i2c.i2cData);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("start_word", 32'(i2c.i2cData), 32'(exp_w));
                end
            end
            if (i2c.i2cGo) check("go_while_idle", 32'(configBusy), 32'd1);
            prev_go   = i2c.i2cGo;
            prev_drop = i2c.i2cGo && !i2c.i2cComplete;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_go"},    32'(i2c.i2cGo),   32'd0);
        check({tag, "_data"},  32'(i2c.i2cData), 32'd0);
        check({tag, "_busy"},  32'(configBusy),  32'd0);
        check({tag, "_done"},  32'(configDone),  32'd0);
        check({tag, "_err"},   32'(configError), 32'd0);
        check({tag, "_index"}, 32'(entryIndex),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge refClock); #1;
        reset = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge refClock);
        @(negedge refClock);
        check_reset_outputs(tag);
        @(posedge refClock); #1;
        reset = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && configDone) && n < LIMIT) begin
            @(negedge refClock);
            n++;
        end
        check({tag, "_bound"}, 32'(n < LIMIT), 32'd1);
        repeat (10) @(negedge refClock);
        check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_done"},    32'(configDone),  32'd1);
        check({tag, "_err"},     32'(configError), 32'(exp_err));
        check({tag, "_busy"},    32'(configBusy),  32'd0);
        check({tag, "_index"},   32'(entryIndex),  32'd11);
        check({tag, "_go"},      32'(i2c.i2cGo),   32'd0);
    endtask

    initial begin
        int n;
        int ri;
        reset = 1'b1;
`ifdef HDMI_HPD_REINIT_EN
        hpd = 1'b0;
`endif
        exp_err = 1'b0;
        repeat (3) @(posedge refClock);
        @(negedge refClock);
        check_reset_outputs("por");
        @(posedge refClock); #1;
        reset = 1'b0;

        // Responsive writer with random timing.
        expect_sequence(1'b0, 0);
        wait_done("normal");

        // Writer drops complete exactly 3 cycles after the start.
        fixed_drop = 3;
        do_reset("rst_b");
        expect_sequence(1'b0, 0);
        wait_done("drop3");
        fixed_drop = 0;

        // Writer ignores entry 5: four attempts, then the sequence continues.
        ign_en   = 1'b1;
        ign_word = CFG_TABLE[5];
        do_reset("rst_c");
        expect_sequence(1'b1, 5);
        wait_done("ign5");

        // Writer ignores a random entry.
        ri       = int'($urandom_range(0, 11));
        ign_word = CFG_TABLE[ri];
        do_reset("rst_e");
        expect_sequence(1'b1, ri);
        wait_done("ign_rand");
        ign_en = 1'b0;

        // Reset while entry 3 is in BUSY; the sequence restarts from the top.
        busy_lo = 12;
        do_reset("rst_d");
        expect_sequence(1'b0, 0);
        n = 0;
        while (!(i2c.i2cGo && i2c.i2cData == CFG_TABLE[3]) && n < LIMIT) begin
            @(negedge refClock);
            n++;
        end
        check("entry3_start_bound", 32'(n < LIMIT), 32'd1);
        n = 0;
        while (!(!i2c.i2cGo && !i2c.i2cComplete) && n < LIMIT) begin
            @(negedge refClock);
            n++;
        end
        check("entry3_busy_bound", 32'(n < LIMIT), 32'd1);
        @(posedge refClock); #1;
        reset = 1'b1;
        sb_q.delete();
        @(posedge refClock);
        @(negedge refClock);
        check_reset_outputs("midrst");
        @(posedge refClock); #1;
        reset = 1'b0;
        expect_sequence(1'b0, 0);
        wait_done("restart");
        busy_lo = 1;

`ifdef HDMI_HPD_REINIT_EN
        // hpd pulse mid-sequence is ignored; a pulse in DONE reissues the table.
        do_reset("rst_f");
        expect_sequence(1'b0, 0);
        n = 0;
        while (entryIndex != 4'd4 && n < LIMIT) begin
            @(negedge refClock);
            n++;
        end
        check("hpd_mid_bound", 32'(n < LIMIT), 32'd1);
        @(posedge refClock); #1 hpd = 1'b1;
        repeat (4) @(posedge refClock);
        #1 hpd = 1'b0;
        wait_done("hpd_mid");
        expect_sequence(1'b0, 0);
        @(posedge refClock); #1 hpd = 1'b1;
        repeat (4) @(posedge refClock);
        #1 hpd = 1'b0;
        @(negedge refClock);
        check("hpd_done_clear", 32'(configDone), 32'd0);
        wait_done("hpd_reinit");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
